// File: rtl/fifo4_ctrl_if.sv
// fifo4_ctrl_if: handshake/data bundle for the 4-entry FIFO.
// overflow/underflow exist only when FIFO4_OVF_FLAGS_EN is defined.
interface fifo4_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
  logic [2:0]       count;
`ifdef FIFO4_OVF_FLAGS_EN
  logic             overflow;
  logic             underflow;

  modport master (output wr_en, din, rd_en,
                  input  dout, full, empty, count, overflow, underflow);
  modport slave  (input  wr_en, din, rd_en,
                  output dout, full, empty, count, overflow, underflow);
`else
  modport master (output wr_en, din, rd_en,
                  input  dout, full, empty, count);
  modport slave  (input  wr_en, din, rd_en,
                  output dout, full, empty, count);
`endif
endinterface

// File: rtl/fifo4_ctrl.sv
// fifo4_ctrl: 4-deep synchronous FIFO with wrap-bit pointers.
// Optional sticky overflow/underflow flags under macro FIFO4_OVF_FLAGS_EN.
// Reset is synchronous, active-low; the storage array is never reset.
module fifo4_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  fifo4_ctrl_if.slave  bus
);

  logic [2:0]       wp_q, wp_d;
  logic [2:0]       rp_q, rp_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] mem_q [4];
  logic [WIDTH-1:0] mem_d [4];
  logic             full_w, empty_w;
  logic             wr_acc, rd_acc;

  // Status straight from registered pointers: address match plus wrap compare
  assign empty_w = (wp_q == rp_q);
  assign full_w  = (wp_q[1:0] == rp_q[1:0]) && (wp_q[2] != rp_q[2]);

  // Next-state: accept writes unless full, reads unless empty
  always_comb begin
    wr_acc = bus.wr_en && !full_w && rst_n;
    rd_acc = bus.rd_en && !empty_w;
    wp_d   = wp_q;
    rp_d   = rp_q;
    dout_d = dout_q;
    mem_d  = mem_q;
    if (wr_acc) begin
      mem_d[wp_q[1:0]] = bus.din;
      wp_d             = wp_q + 3'd1;
    end
    if (rd_acc) begin
      dout_d = mem_q[rp_q[1:0]];
      rp_d   = rp_q + 3'd1;
    end
  end

  // Pointer and read-data registers; reset wins over any request
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q   <= 3'd0;
      rp_q   <= 3'd0;
      dout_q <= '0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      dout_q <= dout_d;
    end
  end

  // Storage array, no reset (writes are gated off while rst_n is low)
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.dout  = dout_q;
  assign bus.full  = full_w;
  assign bus.empty = empty_w;
  assign bus.count = wp_q - rp_q;

`ifdef FIFO4_OVF_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Sticky error flags: set on a dropped request, cleared only by reset
  always_comb begin
    ovf_d = ovf_q | (bus.wr_en & full_w);
    unf_d = unf_q | (bus.rd_en & empty_w);
  end

  // Flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`endif

endmodule

// File: tb/tb_fifo4_ctrl.sv
// tb_fifo4_ctrl: directed scenarios plus randomized traffic against a queue model.
module tb_fifo4_ctrl;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  logic [7:0] mq[$];
  logic [7:0] dout_m;
  bit         ovf_m, unf_m;

  fifo4_ctrl_if #(.WIDTH(8)) bus ();

  fifo4_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock: drive at negedge, update the model at posedge, settle 1 time unit
  task automatic step(input bit rn, input bit wr, input bit rd, input logic [7:0] d);
    int n;
    @(negedge clk);
    rst_n     = rn;
    bus.wr_en = wr;
    bus.rd_en = rd;
    bus.din   = d;
    @(posedge clk);
    n = mq.size();
    if (!rn) begin
      mq.delete();
      dout_m = 8'h00;
      ovf_m  = 1'b0;
      unf_m  = 1'b0;
    end else begin
      if (rd && n != 0) dout_m = mq.pop_front();
      if (wr && n != 4) mq.push_back(d);
      if (wr && n == 4) ovf_m = 1'b1;
      if (rd && n == 0) unf_m = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    n_chk++; if (bus.empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", bus.empty); else n_pass++;
    n_chk++; if (bus.full !== 1'b0) $display("FAIL reset_full got %b exp 0", bus.full); else n_pass++;
    n_chk++; if (bus.count !== 3'd0) $display("FAIL reset_count got %0d exp 0", bus.count); else n_pass++;
    n_chk++; if (bus.dout !== 8'h00) $display("FAIL reset_dout got %h exp 00", bus.dout); else n_pass++;
`ifdef FIFO4_OVF_FLAGS_EN
    n_chk++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0)
      $display("FAIL reset_flags got %b%b exp 00", bus.overflow, bus.underflow); else n_pass++;
`endif
  endtask

  task automatic test_fill_drain();
    logic [7:0] v [4];
    v[0] = 8'h11; v[1] = 8'h22; v[2] = 8'h33; v[3] = 8'h44;
    step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (bus.full !== 1'b0) $display("FAIL fill_notfull[%0d] got %b exp 0", i, bus.full); else n_pass++;
      step(1'b1, 1'b1, 1'b0, v[i]);
    end
    n_chk++; if (bus.full !== 1'b1) $display("FAIL fill_full got %b exp 1", bus.full); else n_pass++;
    n_chk++; if (bus.count !== 3'd4) $display("FAIL fill_count got %0d exp 4", bus.count); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'h00);
      n_chk++; if (bus.dout !== v[i]) $display("FAIL drain_dout[%0d] got %h exp %h", i, bus.dout, v[i]); else n_pass++;
    end
    n_chk++; if (bus.empty !== 1'b1) $display("FAIL drain_empty got %b exp 1", bus.empty); else n_pass++;
    step(1'b1, 1'b0, 1'b0, 8'h00);
    n_chk++; if (bus.dout !== 8'h44) $display("FAIL dout_hold got %h exp 44", bus.dout); else n_pass++;
  endtask

  task automatic test_overflow();
    step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'hA0 + 8'(i));
    step(1'b1, 1'b1, 1'b0, 8'h55);
    n_chk++; if (bus.count !== 3'd4) $display("FAIL ovf_count got %0d exp 4", bus.count); else n_pass++;
`ifdef FIFO4_OVF_FLAGS_EN
    n_chk++; if (bus.overflow !== 1'b1) $display("FAIL ovf_set got %b exp 1", bus.overflow); else n_pass++;
`endif
    step(1'b1, 1'b0, 1'b0, 8'h00);
`ifdef FIFO4_OVF_FLAGS_EN
    n_chk++; if (bus.overflow !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", bus.overflow); else n_pass++;
`endif
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'h00);
      n_chk++; if (bus.dout !== 8'hA0 + 8'(i)) $display("FAIL ovf_drain[%0d] got %h exp %h", i, bus.dout, 8'hA0 + 8'(i)); else n_pass++;
    end
    n_chk++; if (bus.empty !== 1'b1) $display("FAIL ovf_dropped got empty=%b exp 1", bus.empty); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [7:0] exp;
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h01);
    step(1'b1, 1'b1, 1'b0, 8'h02);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b1, 8'h10 + 8'(i));
      exp = (i == 0) ? 8'h01 : (i == 1) ? 8'h02 : 8'h10 + 8'(i - 2);
      n_chk++; if (bus.count !== 3'd2) $display("FAIL wrap_count[%0d] got %0d exp 2", i, bus.count); else n_pass++;
      n_chk++; if (bus.dout !== exp) $display("FAIL wrap_dout[%0d] got %h exp %h", i, bus.dout, exp); else n_pass++;
    end
    step(1'b1, 1'b0, 1'b1, 8'h00);
    n_chk++; if (bus.dout !== 8'h18) $display("FAIL wrap_tail0 got %h exp 18", bus.dout); else n_pass++;
    step(1'b1, 1'b0, 1'b1, 8'h00);
    n_chk++; if (bus.dout !== 8'h19) $display("FAIL wrap_tail1 got %h exp 19", bus.dout); else n_pass++;
    n_chk++; if (bus.empty !== 1'b1) $display("FAIL wrap_empty got %b exp 1", bus.empty); else n_pass++;
  endtask

  task automatic test_simultaneous();
    step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'hC0 + 8'(i));
    step(1'b1, 1'b1, 1'b1, 8'hEE);
    n_chk++; if (bus.count !== 3'd3) $display("FAIL simfull_count got %0d exp 3", bus.count); else n_pass++;
    n_chk++; if (bus.dout !== 8'hC0) $display("FAIL simfull_dout got %h exp c0", bus.dout); else n_pass++;
    for (int i = 1; i < 4; i++) step(1'b1, 1'b0, 1'b1, 8'h00);
    n_chk++; if (bus.dout !== 8'hC3 || bus.empty !== 1'b1)
      $display("FAIL simfull_drain got dout=%h empty=%b exp c3/1", bus.dout, bus.empty); else n_pass++;
`ifdef FIFO4_OVF_FLAGS_EN
    n_chk++; if (bus.underflow !== 1'b0) $display("FAIL unf_clear got %b exp 0", bus.underflow); else n_pass++;
`endif
    step(1'b1, 1'b1, 1'b1, 8'h5A);
    n_chk++; if (bus.count !== 3'd1) $display("FAIL simempty_count got %0d exp 1", bus.count); else n_pass++;
    n_chk++; if (bus.dout !== 8'hC3) $display("FAIL simempty_dout got %h exp c3", bus.dout); else n_pass++;
`ifdef FIFO4_OVF_FLAGS_EN
    n_chk++; if (bus.underflow !== 1'b1) $display("FAIL unf_set got %b exp 1", bus.underflow); else n_pass++;
`endif
    step(1'b1, 1'b0, 1'b1, 8'h00);
    n_chk++; if (bus.dout !== 8'h5A) $display("FAIL simempty_read got %h exp 5a", bus.dout); else n_pass++;
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 8'h70 + 8'(i));
    step(1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h73);
    n_chk++; if (bus.count !== 3'd3) $display("FAIL rstmid_pre got %0d exp 3", bus.count); else n_pass++;
    step(1'b0, 1'b1, 1'b0, 8'h77);
    n_chk++; if (bus.empty !== 1'b1 || bus.count !== 3'd0)
      $display("FAIL rstmid_state got empty=%b count=%0d exp 1/0", bus.empty, bus.count); else n_pass++;
    n_chk++; if (bus.dout !== 8'h00) $display("FAIL rstmid_dout got %h exp 00", bus.dout); else n_pass++;
    step(1'b1, 1'b0, 1'b1, 8'h00);
    n_chk++; if (bus.empty !== 1'b1 || bus.dout !== 8'h00)
      $display("FAIL rstmid_nostore got empty=%b dout=%h exp 1/00", bus.empty, bus.dout); else n_pass++;
  endtask

  task automatic test_random();
    bit rn, wr, rd;
    step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 400; i++) begin
      rn = ($urandom_range(0, 39) != 0);
      wr = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 70 : 30));
      rd = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 30 : 70));
      step(rn, wr, rd, 8'($urandom));
      n_chk++; if (bus.count !== 3'(mq.size())) $display("FAIL rnd_count[%0d] got %0d exp %0d", i, bus.count, mq.size()); else n_pass++;
      n_chk++; if (bus.full !== (mq.size() == 4)) $display("FAIL rnd_full[%0d] got %b", i, bus.full); else n_pass++;
      n_chk++; if (bus.empty !== (mq.size() == 0)) $display("FAIL rnd_empty[%0d] got %b", i, bus.empty); else n_pass++;
      n_chk++; if (bus.dout !== dout_m) $display("FAIL rnd_dout[%0d] got %h exp %h", i, bus.dout, dout_m); else n_pass++;
`ifdef FIFO4_OVF_FLAGS_EN
      n_chk++; if (bus.overflow !== ovf_m || bus.underflow !== unf_m)
        $display("FAIL rnd_flags[%0d] got %b%b exp %b%b", i, bus.overflow, bus.underflow, ovf_m, unf_m); else n_pass++;
`endif
    end
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.din   = 8'h00;
    dout_m    = 8'h00;
    ovf_m     = 1'b0;
    unf_m     = 1'b0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

endmodule
